// File: rtl/z_depth_test.sv
// Tile depth-test stage: compares fragment z against a 2^TB x 2^TB on-chip
// z-buffer, conditionally updates it, and owns clearing it to ZFAR.
module z_depth_test #(
  parameter int unsigned   ZW   = 27,
  parameter int unsigned   TB   = 5,
  parameter logic [ZW-1:0] ZFAR = {1'b0, {(ZW-1){1'b1}}}
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_start_i,
  output logic          busy_o,
  input  logic [1:0]    depth_func_i,
  input  logic          zwrite_en_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [TB-1:0] in_x_i,
  input  logic [TB-1:0] in_y_i,
  input  logic [ZW-1:0] in_z_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [TB-1:0] out_x_o,
  output logic [TB-1:0] out_y_o,
  output logic [ZW-1:0] out_z_o,
  output logic          out_pass_o
);

  localparam int unsigned AW    = 2 * TB;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            clr_we;

  logic            s1_valid_q, s1_valid_d;
  logic [TB-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [ZW-1:0]   s1_z_q, s1_z_d;

  logic            out_valid_q, out_valid_d, out_pass_q, out_pass_d;
  logic [TB-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
  logic [ZW-1:0]   out_z_q, out_z_d;

  logic            lw_valid_q, lw_valid_d;
  logic [AW-1:0]   lw_addr_q, lw_addr_d;
  logic [ZW-1:0]   lw_data_q, lw_data_d;

  logic [ZW-1:0]   mem [DEPTH];
  logic [ZW-1:0]   ram_rd_q;

  logic            accept, out_hold, s1_adv, pass_c, frag_we, ram_we;
  logic [AW-1:0]   s1_addr, ram_waddr;
  logic [ZW-1:0]   ram_wdata, zbuf_c;
  logic signed [ZW:0] key_z, key_b;

  // Sign-magnitude to two's complement so that +0 and -0 compare equal.
  function automatic logic signed [ZW:0] z_key(input logic [ZW-1:0] z);
    logic signed [ZW:0] m;
    m = $signed({2'b00, z[ZW-2:0]});
    return z[ZW-1] ? -m : m;
  endfunction

  assign out_hold   = out_valid_q && !out_ready_i;
  assign s1_adv     = s1_valid_q && !out_hold;
  assign in_ready_o = (state_q == IDLE) && !(s1_valid_q && out_hold) && !clear_start_i;
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != IDLE);
  assign s1_addr    = {s1_y_q, s1_x_q};

  // Depth compare, forwarding the most recent write over the stale RAM read.
  always_comb begin
    zbuf_c = ram_rd_q;
    if (lw_valid_q && (lw_addr_q == s1_addr)) zbuf_c = lw_data_q;
    key_z  = z_key(s1_z_q);
    key_b  = z_key(zbuf_c);
    unique case (depth_func_i)
      2'd0:    pass_c = (key_z < key_b);
      2'd1:    pass_c = (key_z <= key_b);
      2'd2:    pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

  // Single RAM write port shared by fragment updates and the clear sweep.
  always_comb begin
    frag_we   = s1_adv && pass_c && zwrite_en_i;
    ram_we    = clr_we || frag_we;
    ram_waddr = clr_we ? cnt_q : s1_addr;
    ram_wdata = clr_we ? ZFAR : s1_z_q;
  end

  // Clear-control FSM next state: drain the pipe, then sweep every address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      IDLE:  if (clear_start_i) state_d = DRAIN;
      DRAIN: if (!s1_valid_q && !out_valid_q) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + AW'(1);
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline and last-write forwarding register next state.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_z_d      = s1_z_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    out_pass_d  = out_pass_q;
    lw_valid_d  = lw_valid_q;
    lw_addr_d   = lw_addr_q;
    lw_data_d   = lw_data_q;
    if (!out_hold) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_x_d    = s1_x_q;
        out_y_d    = s1_y_q;
        out_z_d    = s1_z_q;
        out_pass_d = pass_c;
      end
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = in_x_i;
      s1_y_d     = in_y_i;
      s1_z_d     = in_z_i;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (ram_we) begin
      lw_valid_d = 1'b1;
      lw_addr_d  = ram_waddr;
      lw_data_d  = ram_wdata;
    end
    if ((state_q == CLEAR) && (&cnt_q)) lw_valid_d = 1'b0;
  end

  // State registers; reset drops any in-flight fragment and starts a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_z_q      <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_pass_q  <= 1'b0;
      lw_valid_q  <= 1'b0;
      lw_addr_q   <= '0;
      lw_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_z_q      <= s1_z_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      out_pass_q  <= out_pass_d;
      lw_valid_q  <= lw_valid_d;
      lw_addr_q   <= lw_addr_d;
      lw_data_q   <= lw_data_d;
    end
  end

  // Tile z-buffer; read data register only loads on accept so it holds through stalls.
  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (accept) ram_rd_q <= mem[{in_y_i, in_x_i}];
  end

  assign out_valid_o = out_valid_q;
  assign out_x_o     = out_x_q;
  assign out_y_o     = out_y_q;
  assign out_z_o     = out_z_q;
  assign out_pass_o  = out_pass_q;

endmodule
